// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: FIFO of completed results feeding the register-file write port, with busy mask and youngest-first forwarding.
module regfile_wb_queue #(
  parameter int DEPTH    = 4,
  parameter int LINK_REG = 31
) (
  input  logic                     Clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_sel,
  input  logic [4:0]               in_rd,
  input  logic [31:0]              in_alu,
  input  logic [31:0]              in_mem,
  input  logic [31:0]              in_pc,
  input  logic                     flush,
  input  logic                     wb_hold,
  output logic                     RegWrite,
  output logic [4:0]               WriteReg,
  output logic [31:0]              WriteData,
  output logic [31:0]              busy_mask,
  input  logic [4:0]               fwd_reg,
  output logic                     fwd_hit,
  output logic [31:0]              fwd_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [4:0]    rd_q   [DEPTH];
  logic [4:0]    rd_d   [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   data_d [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d, slot;
  logic [CW-1:0] count_q, count_d;
  logic          wr_en_q, wr_en_d, push, pop;
  logic [4:0]    wr_reg_q, wr_reg_d, new_rd;
  logic [31:0]   wr_data_q, wr_data_d, new_data;
  assign in_ready  = rst & ~flush & (count_q < CW'(DEPTH));
  assign RegWrite  = wr_en_q;
  assign WriteReg  = wr_reg_q;
  assign WriteData = wr_data_q;
  assign count     = count_q;
  always_comb begin
    push      = in_valid & in_ready & (in_sel != 2'b11);
    pop       = (count_q != '0) & ~wb_hold & ~flush;
    new_rd    = (in_sel == 2'b10) ? 5'(LINK_REG) : in_rd;
    new_data  = (in_sel == 2'b00) ? in_alu : (in_sel == 2'b01) ? in_mem : in_pc + 32'd4;
    rd_d      = rd_q;
    data_d    = data_q;
    if (push) begin
      rd_d[tail_q]   = new_rd;
      data_d[tail_q] = new_data;
    end
    tail_d    = flush ? tail_q : tail_q + AW'(push);
    head_d    = flush ? tail_q : head_q + AW'(pop);
    count_d   = flush ? '0 : count_q + CW'(push) - CW'(pop);
    wr_en_d   = pop;
    wr_reg_d  = pop ? rd_q[head_q] : wr_reg_q;
    wr_data_d = pop ? data_q[head_q] : wr_data_q;
  end
  always_comb begin
    busy_mask = wr_en_q ? (32'd1 << wr_reg_q) : '0;
    fwd_hit   = wr_en_q & (wr_reg_q == fwd_reg);
    fwd_data  = fwd_hit ? wr_data_q : '0;
    slot      = head_q;
    for (int k = 0; k < DEPTH; k++) begin
      slot = head_q + AW'(k);
      if (CW'(k) < count_q) begin
        busy_mask = busy_mask | (32'd1 << rd_q[slot]);
        if (rd_q[slot] == fwd_reg) begin
          fwd_hit  = 1'b1;
          fwd_data = data_q[slot];
        end
      end
    end
  end
  always_ff @(posedge Clk or negedge rst)
    if (!rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
      rd_q      <= rd_d;
      data_q    <= data_d;
    end
endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb_regfile_wb_queue: directed self-checking bench for regfile_wb_queue.
module tb_regfile_wb_queue;
  logic        Clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, wb_hold, RegWrite, fwd_hit;
  logic [1:0]  in_sel;
  logic [4:0]  in_rd, WriteReg, fwd_reg;
  logic [31:0] in_alu, in_mem, in_pc, WriteData, busy_mask, fwd_data;
  logic [2:0]  count;
  int checks = 0;
  int failures = 0;
  regfile_wb_queue #(.DEPTH(4), .LINK_REG(31)) dut (
    .Clk(Clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .in_rd(in_rd), .in_alu(in_alu), .in_mem(in_mem), .in_pc(in_pc), .flush(flush),
    .wb_hold(wb_hold), .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .busy_mask(busy_mask), .fwd_reg(fwd_reg), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .count(count)
  );
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [1:0] sel, input logic [4:0] rd, input logic [31:0] d);
    in_valid = v;
    in_sel   = sel;
    in_rd    = rd;
    in_alu   = d;
    in_mem   = d;
    in_pc    = d;
  endtask
  initial begin
    rst = 1'b0; flush = 1'b0; wb_hold = 1'b0; fwd_reg = 5'd0;
    drive(1'b0, 2'b00, 5'd0, 32'd0);
    #2;
    chk("rst_regwrite", 32'(RegWrite), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", busy_mask, 32'd0);
    chk("rst_fwd_hit", 32'(fwd_hit), 32'd0);
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    drive(1'b1, 2'b00, 5'd5, 32'hDEADBEEF);
    tick();
    drive(1'b0, 2'b00, 5'd0, 32'd0);
    fwd_reg = 5'd5;
    #1;
    chk("alu_n_regwrite", 32'(RegWrite), 32'd0);
    chk("alu_n_count", 32'(count), 32'd1);
    chk("alu_n_busy", busy_mask, 32'h20);
    chk("alu_n_fwd_hit", 32'(fwd_hit), 32'd1);
    chk("alu_n_fwd_data", fwd_data, 32'hDEADBEEF);
    tick();
    chk("alu_n1_regwrite", 32'(RegWrite), 32'd1);
    chk("alu_n1_writereg", 32'(WriteReg), 32'd5);
    chk("alu_n1_writedata", WriteData, 32'hDEADBEEF);
    chk("alu_n1_busy", busy_mask, 32'h20);
    chk("alu_n1_count", 32'(count), 32'd0);
    tick();
    chk("alu_n2_regwrite", 32'(RegWrite), 32'd0);
    chk("alu_n2_busy", busy_mask, 32'd0);
    chk("alu_n2_hold_data", WriteData, 32'hDEADBEEF);
    drive(1'b1, 2'b10, 5'd7, 32'hFFFFFFFC);
    tick();
    drive(1'b0, 2'b00, 5'd0, 32'd0);
    chk("link_busy", busy_mask, 32'h80000000);
    tick();
    chk("link_regwrite", 32'(RegWrite), 32'd1);
    chk("link_writereg", 32'(WriteReg), 32'd31);
    chk("link_writedata", WriteData, 32'h00000000);
    tick();
    drive(1'b1, 2'b11, 5'd8, 32'h12345678);
    #1;
    chk("rsv_ready", 32'(in_ready), 32'd1);
    tick();
    drive(1'b0, 2'b00, 5'd0, 32'd0);
    chk("rsv_count", 32'(count), 32'd0);
    chk("rsv_busy", busy_mask, 32'd0);
    wb_hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 2'b00, 5'(i), 32'(i * 256));
      tick();
    end
    drive(1'b1, 2'b00, 5'd10, 32'hAAAA);
    #1;
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", 32'(in_ready), 32'd0);
    chk("full_busy", busy_mask, 32'h1E);
    tick();
    chk("full_5th_refused", 32'(count), 32'd4);
    drive(1'b0, 2'b00, 5'd0, 32'd0);
    wb_hold = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("drain_regwrite", 32'(RegWrite), 32'd1);
      chk("drain_writereg", 32'(WriteReg), 32'(i));
      chk("drain_writedata", WriteData, 32'(i * 256));
    end
    tick();
    chk("drain_done_regwrite", 32'(RegWrite), 32'd0);
    chk("drain_done_count", 32'(count), 32'd0);
    wb_hold = 1'b1;
    fwd_reg = 5'd3;
    drive(1'b1, 2'b00, 5'd3, 32'h11);
    tick();
    drive(1'b1, 2'b01, 5'd3, 32'h22);
    tick();
    drive(1'b0, 2'b00, 5'd0, 32'd0);
    #1;
    chk("fwd_hit_two", 32'(fwd_hit), 32'd1);
    chk("fwd_data_young", fwd_data, 32'h22);
    wb_hold = 1'b0;
    tick();
    chk("fwd_fifo_over_out", fwd_data, 32'h22);
    chk("fwd_out_first", WriteData, 32'h11);
    tick();
    chk("fwd_out_only_hit", 32'(fwd_hit), 32'd1);
    chk("fwd_out_only_data", fwd_data, 32'h22);
    tick();
    chk("fwd_gone_hit", 32'(fwd_hit), 32'd0);
    chk("fwd_gone_data", fwd_data, 32'd0);
    wb_hold = 1'b1;
    for (int i = 6; i <= 8; i++) begin
      drive(1'b1, 2'b00, 5'(i), 32'(i));
      tick();
    end
    drive(1'b0, 2'b00, 5'd0, 32'd0);
    wb_hold = 1'b0;
    tick();
    chk("pre_flush_count", 32'(count), 32'd2);
    flush = 1'b1;
    drive(1'b1, 2'b00, 5'd9, 32'h99);
    #1;
    chk("flush_ready", 32'(in_ready), 32'd0);
    chk("flush_cycle_regwrite", 32'(RegWrite), 32'd1);
    chk("flush_cycle_writereg", 32'(WriteReg), 32'd6);
    tick();
    flush = 1'b0;
    drive(1'b0, 2'b00, 5'd0, 32'd0);
    #1;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_busy", busy_mask, 32'd0);
    chk("flush_regwrite", 32'(RegWrite), 32'd0);
    tick();
    chk("flush_no_rd9", 32'(RegWrite), 32'd0);
    wb_hold = 1'b1;
    for (int i = 12; i <= 14; i++) begin
      drive(1'b1, 2'b00, 5'(i), 32'(i));
      tick();
    end
    wb_hold = 1'b0;
    drive(1'b1, 2'b00, 5'd15, 32'd15);
    tick();
    drive(1'b0, 2'b00, 5'd0, 32'd0);
    chk("mid_count", 32'(count), 32'd3);
    chk("mid_regwrite", 32'(RegWrite), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_regwrite", 32'(RegWrite), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_busy", busy_mask, 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd0);
    chk("arst_writereg", 32'(WriteReg), 32'd0);
    chk("arst_writedata", WriteData, 32'd0);
    tick();
    rst = 1'b1;
    #1;
    chk("arst_release_ready", 32'(in_ready), 32'd1);
    drive(1'b1, 2'b01, 5'd20, 32'hCAFEF00D);
    tick();
    drive(1'b0, 2'b00, 5'd0, 32'd0);
    tick();
    chk("load_writereg", 32'(WriteReg), 32'd20);
    chk("load_writedata", WriteData, 32'hCAFEF00D);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_wb_queue.md
# regfile_wb_queue

Writeback queue sitting directly upstream of the 32x32 register file write port. It accepts completed results from execute (ALU result, load data, or branch-and-link return address) through a valid/ready handshake and buffers them in a DEPTH-entry FIFO. It retires at most one entry per cycle onto the register file's RegWrite/WriteReg/WriteData inputs. It also publishes a pending-write busy mask and a forwarding lookup so the decode stage can detect and bypass RAW hazards on registers not yet committed.

## Interface
- DEPTH, 4, FIFO entries; power of two, 2..16
- LINK_REG, 31, destination forced for link writes
- Clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous assert, active-low (0 = reset)
- in_valid  in  1  execute presents a result
- in_ready  out  1  queue can accept this cycle
- in_sel  in  2  source select: 00 ALU, 01 load data, 10 link, 11 reserved
- in_rd  in  5  destination register (ignored for link)
- in_alu  in  32  ALU result
- in_mem  in  32  load data
- in_pc  in  32  PC of the branch-and-link instruction
- flush  in  1  synchronous discard of all queued entries
- wb_hold  in  1  suppress retirement this cycle
- RegWrite  out  1  register-file write enable (registered)
- WriteReg  out  5  register-file write address (registered)
- WriteData  out  32  register-file write data (registered)
- busy_mask  out  32  bit i = 1 while a write to register i is pending
- fwd_reg  in  5  register queried by decode
- fwd_hit  out  1  a pending write to fwd_reg exists
- fwd_data  out  32  data of the youngest pending write to fwd_reg
- count  out  $clog2(DEPTH)+1  occupied FIFO entries

## Operation
- Enqueue on in_valid & in_ready.
- The stored entry is {rd, data}, where data = in_alu (00), in_mem (01), or in_pc+4 with rd = LINK_REG (10). The +4 wraps modulo 2^32.
- in_sel 11 is accepted (handshake completes) but creates no entry.
- in_ready = (count < DEPTH) & ~flush. It is 0 while rst is low. There is no combinational path from pop to in_ready, so a full queue refuses input even in a cycle where it drains.
- Retire: each cycle with count > 0, ~wb_hold and ~flush, the head is popped into the output register: RegWrite=1, WriteReg=rd, WriteData=data. Otherwise RegWrite=0, and WriteReg/WriteData hold their last values.
- Simultaneous enqueue and pop: count is unchanged. Pointers wrap modulo DEPTH.
- Flush: at the edge, head = tail and count = 0, and any same-cycle enqueue is discarded. A RegWrite already asserted in the flush cycle still commits, because the register file samples at that same edge.
- busy_mask: combinational OR of decoded rd over all valid FIFO entries, plus WriteReg when RegWrite = 1.
- Forwarding: fwd_hit and fwd_data are combinational.
  - Priority, youngest first: FIFO entries from tail-1 back to head, then the output register when RegWrite = 1.
  - fwd_data = 0 when fwd_hit = 0.
- Repeated writes to the same rd are kept as separate entries and retire in order.

## Timing
- Reset (rst low, asynchronous):
  - RegWrite=0, WriteReg=0, WriteData=0
  - count=0, pointers=0, busy_mask=0, fwd_hit=0, in_ready=0
- Release of rst is synchronous to Clk. in_ready=1 on the first cycle after release.
- Latency:
  - Entry accepted at edge N; RegWrite=1 during cycle N+1 to N+2.
  - The register file holds the value after edge N+2.
  - busy_mask bit set from just after edge N until edge N+2.
- Throughput: one retirement per cycle.
- Reset asserted mid-operation: all entries are lost immediately, and no partial write is issued.

## Test plan
- Reset check: rst=0 mid-stream with 3 entries queued -> RegWrite, count and busy_mask drop to 0 asynchronously, and in_ready=0. After release, in_ready=1.
- Single ALU write: in_sel=00, in_rd=5, in_alu=0xDEADBEEF at edge N.
  - RegWrite=1, WriteReg=5, WriteData=0xDEADBEEF in cycle N+1 only.
  - busy_mask=0x20 from N to N+2.
- Link write: in_sel=10, in_rd=7, in_pc=0xFFFFFFFC -> WriteReg=31, WriteData=0x00000000.
- Full/back-pressure: wb_hold=1, push 4 entries -> count=4, in_ready=0, and a 5th push is not accepted. Release wb_hold -> rd order preserved, 4 consecutive RegWrite cycles.
- Forwarding: queue rd=3 data 0x11, then rd=3 data 0x22, with fwd_reg=3 -> fwd_hit=1, fwd_data=0x22. After both retire -> fwd_hit=0, fwd_data=0.
- Flush: with 3 queued entries, assert flush together with in_valid for rd=9 -> next cycle count=0, busy_mask=0, no RegWrite for rd=9. A RegWrite already asserted in the flush cycle completes.
